// File: rtl/magnetron_pwm_ctrl.sv
// Magnetron controller: button edge detect, cook/pause/done FSM, latched power and PWM enable with door interlock.
// Latency: state changes on the edge after a press; Q follows the registered phase, door gating is combinational.
// Backpressure: none; buttons are level inputs sampled every cycle. Optional soft-start: MAGNETRON_SOFTSTART_EN.
module magnetron_pwm_ctrl #(
  parameter int PWR_W       = 4,
  parameter int PERIOD      = 15,
  parameter int SOFT_FRAMES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clearn,
  input  logic             door_closed,
  input  logic             timer_done,
  input  logic [PWR_W-1:0] power,
  output logic             Q,
  output logic             cooking,
  output logic             paused,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;

  // Common compare width: holds power_q + 1 and the value PERIOD itself.
  localparam int PH_W = $clog2(PERIOD);
  localparam int CW_A = PWR_W + 1;
  localparam int CW_B = $clog2(PERIOD + 1);
  localparam int CW   = (CW_A > CW_B) ? CW_A : CW_B;
  localparam logic [CW-1:0]   PERIOD_C = CW'(PERIOD);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PERIOD - 1);

  state_t            state_q;
  logic [PWR_W-1:0]  power_q;
  logic [PH_W-1:0]   phase_q;
  logic              start_q, stop_q, clear_q;
  logic              arm_q;
  logic              start_p, stop_p, clear_p;
  logic [CW-1:0]     pq_ext, on_full, on_time;

  // Button sample registers; arm_q blocks the first edge after reset so a held button is not a press.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      start_q <= 1'b1;
      stop_q  <= 1'b1;
      clear_q <= 1'b1;
      arm_q   <= 1'b0;
    end else begin
      start_q <= startn;
      stop_q  <= stopn;
      clear_q <= clearn;
      arm_q   <= 1'b1;
    end
  end

  assign start_p = arm_q & start_q & ~startn;
  assign stop_p  = arm_q & stop_q  & ~stopn;
  assign clear_p = arm_q & clear_q & ~clearn;

  // Cooking FSM with power latch and PWM phase; phase is held at 0 outside COOK so every entry starts a fresh frame.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      power_q <= '0;
      phase_q <= '0;
    end else begin
      if (state_q == COOK && phase_q != PH_LAST) begin
        phase_q <= phase_q + PH_W'(1);
      end else begin
        phase_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (!clear_p && door_closed && start_p && power != '0) begin
            state_q <= COOK;
            power_q <= power;
          end
        end
        COOK: begin
          if (clear_p)           state_q <= IDLE;
          else if (!door_closed) state_q <= PAUSE;
          else if (timer_done)   state_q <= DONE;
          else if (stop_p)       state_q <= PAUSE;
        end
        PAUSE: begin
          if (clear_p)                     state_q <= IDLE;
          else if (door_closed && start_p) state_q <= COOK;
        end
        DONE: begin
          if (clear_p || !door_closed) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pq_ext  = CW'(power_q);
  assign on_full = (pq_ext > PERIOD_C) ? PERIOD_C : pq_ext;

`ifdef MAGNETRON_SOFTSTART_EN
  localparam int FR_W = (SOFT_FRAMES > 0) ? $clog2(SOFT_FRAMES + 1) : 1;
  localparam logic [FR_W-1:0] SF_C = FR_W'(SOFT_FRAMES);

  logic [FR_W-1:0] frm_q;
  logic [CW-1:0]   on_half;

  // Saturating count of completed frames since the last entry to COOK (including resume from PAUSE).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frm_q <= '0;
    end else if (state_q != COOK) begin
      frm_q <= '0;
    end else if (phase_q == PH_LAST && frm_q != SF_C) begin
      frm_q <= frm_q + FR_W'(1);
    end
  end

  assign on_half = (pq_ext + CW'(1)) >> 1;
  assign on_time = (frm_q != SF_C) ? ((on_half > PERIOD_C) ? PERIOD_C : on_half) : on_full;
`else
  assign on_time = on_full;
`endif

  // Status flags decode the registered state only; no input reaches them combinationally.
  assign cooking = (state_q == COOK);
  assign paused  = (state_q == PAUSE);
  assign done    = (state_q == DONE);

  // Door term stays combinational so an open door kills the enable in the same cycle.
  assign Q = cooking & (CW'(phase_q) < on_time) & door_closed;

endmodule

// File: tb/tb_magnetron_pwm_ctrl.sv
// Directed bench for magnetron_pwm_ctrl: stimulus pushes the expected {Q,cooking,paused,done}
// for each cycle into a queue; a negedge monitor pops and compares against the DUT.
// Additional direct reset-state checks, a watchdog timeout and a final scoreboard-drain check.
module tb_magnetron_pwm_ctrl;

    logic       clk = 1'b0;
    logic       resetn, startn, stopn, clearn, door_closed, timer_done;
    logic [3:0] power;
    logic       Q, cooking, paused, done;
    logic       finished = 1'b0;

    always #5 clk = ~clk;

    magnetron_pwm_ctrl #(.PWR_W(4), .PERIOD(15), .SOFT_FRAMES(2)) dut (
        .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .timer_done(timer_done), .power(power),
        .Q(Q), .cooking(cooking), .paused(paused), .done(done)
    );

    typedef struct {
        logic [3:0] v;
        string      nm;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   ck;
    int   pw_lat;

    function automatic logic qexp(input int c, input int pw);
        int on;
        on = pw;
`ifdef MAGNETRON_SOFTSTART_EN
        if (c / 15 < 2) on = (pw + 1) / 2;
`endif
        if (on > 15) on = 15;
        return ((c % 15) < on);
    endfunction

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            checks++;
            if ({Q, cooking, paused, done} !== cur.v) begin
                errors++;
                $display("FAIL %s: got {Q,cook,pause,done}=%b expected %b at %0t", cur.nm,
                         {Q, cooking, paused, done}, cur.v, $time);
            end
        end
    end

    initial begin
        #200000;
        if (!finished) begin
            errors++;
            $display("FAIL timeout: stimulus did not complete at %0t", $time);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic check_now(input logic [3:0] e, input string nm);
        checks++;
        if ({Q, cooking, paused, done} !== e) begin
            errors++;
            $display("FAIL %s (direct): got {Q,cook,pause,done}=%b expected %b at %0t", nm,
                     {Q, cooking, paused, done}, e, $time);
        end
    endtask

    task automatic cyc(input logic [3:0] e, input string nm);
        sb.push_back('{e, nm});
        @(posedge clk);
        #1;
    endtask

    task automatic cook(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            cyc({qexp(ck, pw_lat), 3'b100}, nm);
            ck++;
        end
    endtask

    initial begin
        resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; timer_done = 1'b0; power = 4'd5;
        ck = 0; pw_lat = 0;
        @(posedge clk); #1;
        check_now(4'b0000, "reset_state0");
        cyc(4'b0000, "reset0");
        cyc(4'b0000, "reset1");
        check_now(4'b0000, "reset_state1");
        resetn = 1'b1;
        cyc(4'b0000, "idle_after_reset");
        check_now(4'b0000, "idle_state");

        startn = 1'b0; cyc(4'b0000, "press5"); startn = 1'b1;
        ck = 0; pw_lat = 5;
        cook(30, "pwm5");
        power = 4'd12;
        cook(15, "pwm_latched");

        cook(2, "pre_door");
        door_closed = 1'b0; cyc(4'b0100, "door_drop");
        cyc(4'b0010, "paused");
        startn = 1'b0; cyc(4'b0010, "start_door_open"); startn = 1'b1;
        cyc(4'b0010, "still_paused");
        door_closed = 1'b1; cyc(4'b0010, "door_closed_paused");
        startn = 1'b0; cyc(4'b0010, "resume_press"); startn = 1'b1;
        ck = 0;
        cook(15, "resume_keeps_power");

        timer_done = 1'b1; stopn = 1'b0;
        cyc({qexp(ck, pw_lat), 3'b100}, "tmr_stop");
        timer_done = 1'b0; stopn = 1'b1;
        cyc(4'b0001, "done");
        clearn = 1'b0; cyc(4'b0001, "clear_press"); clearn = 1'b1;
        cyc(4'b0000, "cleared");

        power = 4'd15;
        startn = 1'b0; cyc(4'b0000, "press15"); startn = 1'b1;
        ck = 0; pw_lat = 15;
        cook(30, "pwm15");
        clearn = 1'b0; startn = 1'b0;
        cyc({qexp(ck, pw_lat), 3'b100}, "clr_start");
        clearn = 1'b1; startn = 1'b1;
        cyc(4'b0000, "clear_wins");

        power = 4'd0;
        startn = 1'b0; cyc(4'b0000, "press_p0"); startn = 1'b1;
        cyc(4'b0000, "p0_idle");
        cyc(4'b0000, "p0_idle2");

        power = 4'd5;
        startn = 1'b0; cyc(4'b0000, "hold_press");
        ck = 0; pw_lat = 5;
        cook(39, "hold_cook");
        clearn = 1'b0; cyc({qexp(ck, pw_lat), 3'b100}, "hold_clear"); clearn = 1'b1;
        repeat (3) cyc(4'b0000, "hold_no_retrigger");
        startn = 1'b1; cyc(4'b0000, "hold_release");

        startn = 1'b0; cyc(4'b0000, "press_d"); startn = 1'b1;
        ck = 0;
        cook(3, "cook_d");
        timer_done = 1'b1; cyc({qexp(ck, pw_lat), 3'b100}, "timer"); timer_done = 1'b0;
        cyc(4'b0001, "done_d");
        door_closed = 1'b0; cyc(4'b0001, "door_ack");
        cyc(4'b0000, "ack_idle");
        door_closed = 1'b1;

        startn = 1'b0; cyc(4'b0000, "press_r"); startn = 1'b1;
        ck = 0;
        cook(3, "cook_r");
        resetn = 1'b0; startn = 1'b0;
        cyc({qexp(ck, pw_lat), 3'b100}, "rst_edge");
        check_now(4'b0000, "reset_mid_cook");
        cyc(4'b0000, "in_reset");
        resetn = 1'b1;
        cyc(4'b0000, "rst_release");
        cyc(4'b0000, "held_no_press");
        cyc(4'b0000, "held_no_press2");
        startn = 1'b1; cyc(4'b0000, "released");
        startn = 1'b0; cyc(4'b0000, "press_after_rst"); startn = 1'b1;
        ck = 0;
        cook(5, "cook_after_rst");

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expected vectors never checked", sb.size());
        end
        finished = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/magnetron_pwm_ctrl.md
# magnetron_pwm_ctrl

Clocked, parametrised magnetron controller for the microwave datapath. It replaces the level-2 combinational start/stop/clear latch with a registered cooking state machine, button press detection, a latched power level and PWM duty-cycle generation on the magnetron enable. Door interlock gating is kept combinational so the magnetron can never be on with the door open. It sits between the front-panel/timer logic and the magnetron drive.

## Interface

- `PWR_W`, 4: width of the power-level input.
- `PERIOD`, 15: PWM frame length in clock cycles; must be ≥ 2.
- `SOFT_FRAMES`, 2: number of reduced-duty frames after each entry to COOK (only used with the soft-start macro).

- `clk`  in  1  system clock, all state updates on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `startn`  in  1  start button, active low.
- `stopn`  in  1  stop/pause button, active low.
- `clearn`  in  1  clear button, active low.
- `door_closed`  in  1  1 = door closed.
- `timer_done`  in  1  1 = cooking time expired (level).
- `power`  in  PWR_W  requested power level, 0 = off.
- `Q`  out  1  magnetron enable.
- `cooking`  out  1  state == COOK.
- `paused`  out  1  state == PAUSE.
- `done`  out  1  state == DONE.

## Operation

- Press detect: each button has a sample register reset to 1. A press is register = 1 and input = 0. Holding a button low produces one press only.
- States: IDLE, COOK, PAUSE, DONE. Reset value is IDLE.
- Transition priority, per cycle: clear press > door open > timer_done > stop press > start press.
- IDLE: start press with door_closed = 1 and power ≠ 0 → COOK. `power` is latched into `power_q`. Start with the door open or power = 0 is ignored.
- COOK: clear → IDLE. Door open → PAUSE. timer_done → DONE. Stop → PAUSE. Start is ignored.
- PAUSE: clear → IDLE. Start with door_closed → COOK, keeping the already latched `power_q`.
- DONE: clear → IDLE. Door open → IDLE (opening the door acknowledges completion). Start is ignored.
- PWM: the phase counter runs 0..PERIOD-1 and wraps. It is forced to 0 on every entry to COOK. `on_time` = min(`power_q`, PERIOD); if power exceeds PERIOD, Q stays on for the full frame.
- `Q` = (state == COOK) & (phase < on_time) & `door_closed`. The door term is combinational.
- `power` changes while in COOK or PAUSE have no effect until the next start from IDLE.

## Timing

- All outputs are 0 during reset and after it.
- The input is first seen low before edge k. The state changes at edge k. `Q` first rises in the cycle after edge k (phase 0), provided on_time ≥ 1.
- Door opening drops `Q` in the same cycle. `paused` asserts after the next edge.
- Reset mid-cooking: at the reset edge the state goes to IDLE, phase to 0, `power_q` to 0 and the button registers to 1. A button still held low at reset release does not register as a press.
- Simultaneous events follow the priority above. Example: timer_done and a stop press in the same cycle → DONE.

## Configuration

- `MAGNETRON_SOFTSTART_EN` defined: for the first SOFT_FRAMES frames after each entry to COOK, on_time = min((`power_q`+1)>>1, PERIOD). A frame counter that saturates handles this. Later frames use the full on_time. A resume from PAUSE restarts the soft-start.
- Not defined: full on_time from the first frame. SOFT_FRAMES is unused and no frame counter is synthesised.

## Test plan

- Reset: hold resetn = 0 for 2 cycles with all buttons at 1 → Q = cooking = paused = done = 0 and state is IDLE.
- Cook: door_closed = 1, power = 5, startn low for 1 cycle → cooking = 1 after the edge. Q then repeats 5 cycles high, 10 cycles low with PERIOD = 15. With power = 15, Q stays high continuously.
- Door interlock: open the door at phase 2 → Q = 0 in the same cycle and paused = 1 after the edge. Start with the door open → no change. Close the door and press start → COOK, with Q high starting at phase 0.
- Priority and done: timer_done = 1 and stopn = 0 in the same cycle → done = 1. clearn low → IDLE. In COOK, press clear together with start → IDLE.
- Latch and guard: press start with power = 0 → stays IDLE. Start with power = 5, then change power to 12 mid-cook → Q stays on for 5 cycles per frame. Hold startn low for 40 cycles in IDLE → exactly one transition.
- Soft-start, with the macro defined: power = 5, SOFT_FRAMES = 2 → the first two frames have 3 on-cycles, then 5. Without the macro → 5 on-cycles from the first frame.
